// File: rtl/level_histogram.sv
// Level-code histogram: bins a fixed window of valid samples, counts out-of-range
// codes as clips, then streams the per-bin counts out over a valid/ready handshake.
module level_histogram #(
   parameter int NUM_BINS    = 8,
   parameter int CODE_W      = 6,
   parameter int WINDOW_LOG2 = 8,
   parameter int CNT_W       = WINDOW_LOG2 + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        in_valid,
   input  logic [CODE_W-1:0]           in_code,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(NUM_BINS)-1:0] out_bin,
   output logic [CNT_W-1:0]            out_count,
   output logic [CNT_W-1:0]            out_clip,
   output logic                        out_last
);

   localparam int                BIN_W      = $clog2(NUM_BINS);
   localparam logic [CODE_W-1:0] BINS_C     = CODE_W'(NUM_BINS);
   localparam logic [BIN_W-1:0]  LAST_IDX_C = BIN_W'(NUM_BINS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DUMP  = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [CNT_W-1:0]       bins_r [NUM_BINS];
   logic [WINDOW_LOG2-1:0] sample_cnt_r;
   logic [CNT_W-1:0]       clip_r;
   logic [BIN_W-1:0]       idx_r;
   logic                   sample_s;
   logic                   in_range_s;
   logic                   final_s;
   logic                   xfer_s;
   logic                   last_s;
   logic                   dump_s;

   // Next-state logic and per-cycle event decode.
   always_comb begin
      state_nxt_s = state_r;
      sample_s    = 1'b0;
      final_s     = 1'b0;
      xfer_s      = 1'b0;
      in_range_s  = (in_code < BINS_C);
      last_s      = (idx_r == LAST_IDX_C);
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = ACCUM;
            else       state_nxt_s = IDLE;
         end
         ACCUM: begin
            sample_s = in_valid;
            // The sample counter is all-ones exactly when the window's last sample arrives.
            final_s  = in_valid && (sample_cnt_r == '1);
            if (final_s) state_nxt_s = DUMP;
            else         state_nxt_s = ACCUM;
         end
         DUMP: begin
            xfer_s = out_ready;
            if (out_ready && last_s) state_nxt_s = IDLE;
            else                     state_nxt_s = DUMP;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Bin, clip, sample and dump-index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BINS; i++) bins_r[i] <= '0;
         sample_cnt_r <= '0;
         clip_r       <= '0;
         idx_r        <= '0;
      end else if (state_r == IDLE && start) begin
         for (int i = 0; i < NUM_BINS; i++) bins_r[i] <= '0;
         sample_cnt_r <= '0;
         clip_r       <= '0;
         idx_r        <= '0;
      end else if (sample_s) begin
         if (in_range_s) begin
            bins_r[in_code[BIN_W-1:0]] <= bins_r[in_code[BIN_W-1:0]] + CNT_W'(1);
         end else if (clip_r != '1) begin
            clip_r <= clip_r + CNT_W'(1);
         end
         sample_cnt_r <= sample_cnt_r + WINDOW_LOG2'(1);
         if (final_s) idx_r <= '0;
      end else if (xfer_s) begin
         idx_r <= last_s ? '0 : idx_r + BIN_W'(1);
      end
   end

   // Outputs decoded from registered state only; zero outside DUMP.
   always_comb begin
      dump_s    = (state_r == DUMP);
      busy      = (state_r != IDLE);
      out_valid = dump_s;
      out_bin   = dump_s ? idx_r : '0;
      out_count = dump_s ? bins_r[idx_r] : '0;
      out_clip  = dump_s ? clip_r : '0;
      out_last  = dump_s && last_s;
   end

endmodule

// File: tb/tb_level_histogram.sv
// Self-checking bench for level_histogram: randomized windows against a
// plain-arithmetic histogram model, with backpressure, ignored inputs and resets.
module tb_level_histogram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [5:0] in_code;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_bin;
   logic [8:0] out_count;
   logic [8:0] out_clip;
   logic       out_last;

   int total = 0;
   int bad   = 0;

   int m_bin [8];
   int m_clip;

   logic [2:0] w_bin  [16];
   logic [8:0] w_cnt  [16];
   logic [8:0] w_clip [16];
   logic       w_last [16];
   int         n_words;
   int         stall_changes;

   level_histogram dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_code   (in_code),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_count (out_count),
      .out_clip  (out_clip),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: a histogram is just counts per code, clips saturate at 511.
   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_bin[i] = 0;
      m_clip = 0;
   endtask

   task automatic model_add(input int c);
      if (c < 8) m_bin[c]++;
      else if (m_clip < 511) m_clip++;
   endtask

   // All drive tasks start and end just after a falling edge.
   task automatic feed(input logic v, input logic [5:0] c);
      in_valid = v;
      in_code  = c;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_clear();
   endtask

   // Collect dump words; optionally hold out_ready low for stall_len cycles at stall_bin.
   task automatic collect(input int stall_bin, input int stall_len);
      int stall_left;
      int cyc;
      bit done;
      logic [2:0] sb;
      logic [8:0] sc;
      logic [8:0] sclip;
      logic       sl;
      n_words = 0; stall_changes = 0; stall_left = stall_len; done = 0; cyc = 0;
      sb = '0; sc = '0; sclip = '0; sl = 1'b0;
      while (!done && cyc < 200) begin
         cyc++;
         if (out_valid && int'(out_bin) == stall_bin && stall_left > 0) begin
            if (stall_left == stall_len) begin
               sb = out_bin; sc = out_count; sclip = out_clip; sl = out_last;
            end else if (out_bin !== sb || out_count !== sc || out_clip !== sclip || out_last !== sl) begin
               stall_changes++;
            end
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
            if (out_valid && n_words < 16) begin
               w_bin[n_words]  = out_bin;
               w_cnt[n_words]  = out_count;
               w_clip[n_words] = out_clip;
               w_last[n_words] = out_last;
               n_words++;
               if (out_last) done = 1;
            end
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_bin !== 3'd0 || out_count !== 9'd0 ||
          out_clip !== 9'd0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL reset: got busy=%b vld=%b bin=%0d cnt=%0d clip=%0d last=%b want all 0",
                  busy, out_valid, out_bin, out_count, out_clip, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_constant();
      pulse_start();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL const_busy: got %b want 1", busy); end
      for (int i = 0; i < 255; i++) begin feed(1'b1, 6'd4); model_add(4); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL const_early: out_valid got %b want 0", out_valid); end
      feed(1'b1, 6'd4); model_add(4);
      total++;
      if (out_valid !== 1'b1 || out_bin !== 3'd0) begin
         bad++; $display("FAIL const_latency: got vld=%b bin=%0d want vld=1 bin=0", out_valid, out_bin);
      end
      collect(-1, 0);
      total++;
      if (n_words != 8) begin bad++; $display("FAIL const_nwords: got %0d want 8", n_words); end
      for (int i = 0; i < 8 && i < n_words; i++) begin
         total++;
         if (w_bin[i] !== 3'(i) || w_cnt[i] !== 9'(m_bin[i]) || w_last[i] !== (i == 7) || w_clip[i] !== 9'(m_clip)) begin
            bad++;
            $display("FAIL const_word%0d: got bin=%0d cnt=%0d last=%b clip=%0d want bin=%0d cnt=%0d last=%b clip=%0d",
                     i, w_bin[i], w_cnt[i], w_last[i], w_clip[i], i, m_bin[i], (i == 7), m_clip);
         end
      end
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL const_done: got busy=%b vld=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_ramp();
      pulse_start();
      for (int i = 0; i < 256; i++) begin feed(1'b1, 6'(i % 10)); model_add(i % 10); end
      collect(-1, 0);
      total++;
      if (n_words != 8) begin bad++; $display("FAIL ramp_nwords: got %0d want 8", n_words); end
      for (int i = 0; i < 8 && i < n_words; i++) begin
         total++;
         if (w_bin[i] !== 3'(i) || w_cnt[i] !== 9'(m_bin[i]) || w_last[i] !== (i == 7) || w_clip[i] !== 9'(m_clip)) begin
            bad++;
            $display("FAIL ramp_word%0d: got bin=%0d cnt=%0d last=%b clip=%0d want bin=%0d cnt=%0d last=%b clip=%0d",
                     i, w_bin[i], w_cnt[i], w_last[i], w_clip[i], i, m_bin[i], (i == 7), m_clip);
         end
      end
   endtask

   task automatic test_gaps();
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         feed(1'b1, 6'd1); model_add(1);
         if (i < 255) feed(1'b0, 6'd9);
      end
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL gaps_dump: out_valid got %b want 1", out_valid); end
      collect(-1, 0);
      total++;
      if (n_words != 8) begin bad++; $display("FAIL gaps_nwords: got %0d want 8", n_words); end
      for (int i = 0; i < 8 && i < n_words; i++) begin
         total++;
         if (w_bin[i] !== 3'(i) || w_cnt[i] !== 9'(m_bin[i]) || w_clip[i] !== 9'(m_clip)) begin
            bad++;
            $display("FAIL gaps_word%0d: got bin=%0d cnt=%0d clip=%0d want bin=%0d cnt=%0d clip=%0d",
                     i, w_bin[i], w_cnt[i], w_clip[i], i, m_bin[i], m_clip);
         end
      end
   endtask

   task automatic test_backpressure(input int stall_bin, input int stall_len, input bit gaps);
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         int c;
         c = int'($urandom_range(0, 11));
         if (gaps && $urandom_range(0, 2) == 0) feed(1'b0, 6'($urandom_range(0, 63)));
         feed(1'b1, 6'(c)); model_add(c);
      end
      collect(stall_bin, stall_len);
      total++;
      if (stall_changes != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_changes); end
      total++;
      if (n_words != 8) begin bad++; $display("FAIL bp_nwords: got %0d want 8", n_words); end
      for (int i = 0; i < 8 && i < n_words; i++) begin
         total++;
         if (w_bin[i] !== 3'(i) || w_cnt[i] !== 9'(m_bin[i]) || w_last[i] !== (i == 7) || w_clip[i] !== 9'(m_clip)) begin
            bad++;
            $display("FAIL bp_word%0d: got bin=%0d cnt=%0d last=%b clip=%0d want bin=%0d cnt=%0d last=%b clip=%0d",
                     i, w_bin[i], w_cnt[i], w_last[i], w_clip[i], i, m_bin[i], (i == 7), m_clip);
         end
      end
   endtask

   task automatic test_ignored();
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         int c;
         c = int'($urandom_range(0, 9));
         if (i == 100) start = 1'b1;
         feed(1'b1, 6'(c)); model_add(c);
         start = 1'b0;
      end
      // Samples offered throughout the dump must not be counted.
      in_valid = 1'b1; in_code = 6'd7;
      collect(-1, 0);
      in_valid = 1'b0;
      total++;
      if (n_words != 8) begin bad++; $display("FAIL ign_nwords: got %0d want 8", n_words); end
      for (int i = 0; i < 8 && i < n_words; i++) begin
         total++;
         if (w_bin[i] !== 3'(i) || w_cnt[i] !== 9'(m_bin[i]) || w_clip[i] !== 9'(m_clip)) begin
            bad++;
            $display("FAIL ign_word%0d: got bin=%0d cnt=%0d clip=%0d want bin=%0d cnt=%0d clip=%0d",
                     i, w_bin[i], w_cnt[i], w_clip[i], i, m_bin[i], m_clip);
         end
      end
      // Reset in the middle of a dump, then a clean window.
      pulse_start();
      for (int i = 0; i < 256; i++) feed(1'b1, 6'd3);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 9'd0) begin
         bad++; $display("FAIL rst_dump: got vld=%b busy=%b cnt=%0d want 0 0 0", out_valid, busy, out_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         int c;
         c = int'($urandom_range(0, 15));
         feed(1'b1, 6'(c)); model_add(c);
      end
      collect(-1, 0);
      total++;
      if (n_words != 8) begin bad++; $display("FAIL post_rst_nwords: got %0d want 8", n_words); end
      for (int i = 0; i < 8 && i < n_words; i++) begin
         total++;
         if (w_bin[i] !== 3'(i) || w_cnt[i] !== 9'(m_bin[i]) || w_clip[i] !== 9'(m_clip)) begin
            bad++;
            $display("FAIL post_rst_word%0d: got bin=%0d cnt=%0d clip=%0d want bin=%0d cnt=%0d clip=%0d",
                     i, w_bin[i], w_cnt[i], w_clip[i], i, m_bin[i], m_clip);
         end
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_ramp();
      test_gaps();
      test_backpressure(2, 5, 1'b0);
      test_backpressure(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), 1'b1);
      test_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
